// File: rtl/uart_pkg.sv
// Shared constants, error codes and FSM state encodings for the UART command
// frame sequencer.
package uart_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_CHK  = 2'b01,
      ERR_LEN  = 2'b10,
      ERR_TMO  = 2'b11
   } err_e;

   typedef enum logic [2:0] {
      S_HUNT,
      S_ADDR,
      S_LEN,
      S_DATA,
      S_CHK,
      S_DRAIN
   } state_e;

   // A frame must carry at least one payload byte and no more than the buffer holds.
   function automatic logic len_bad(input logic [7:0] len, input int unsigned max_len);
      return (len == 8'd0) || (32'(len) > max_len);
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int IW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [IW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // NOTE: storage is not reset; every entry is written in DATA before DRAIN reads it.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses SYNC,ADDR,LEN,PAYLOAD,CHK frames from uart_rx and, once the checksum
// passes, replays the buffered payload as a burst of register writes.
module uart_cmd_sequencer
   import uart_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       overrun
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   state_e        state;
   err_e          err_q;
   logic [7:0]    addr;
   logic [7:0]    len;
   logic [7:0]    idx;
   logic [7:0]    chk;
   logic [TW-1:0] tmo_cnt;
   logic          in_frame;
   logic          tmo_hit;
   logic          buf_we;
   logic [7:0]    buf_rdata;

   assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CHK);
   // An arriving byte beats an expiring counter in the same cycle.
   assign tmo_hit  = in_frame && !rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
   assign buf_we   = (state == S_DATA) && rx_valid;
   assign busy     = (state != S_HUNT);
   assign err_code = err_q;

   uart_frame_buf #(
      .DEPTH (MAX_LEN),
      .IW    (IW)
   ) u_frame_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (idx[IW-1:0]),
      .wdata (rx_byte),
      .raddr (idx[IW-1:0]),
      .rdata (buf_rdata)
   );

   // NOTE: all state here uses <= so every branch sees the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_HUNT;
         err_q     <= ERR_NONE;
         addr      <= '0;
         len       <= '0;
         idx       <= '0;
         chk       <= '0;
         tmo_cnt   <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         tmo_cnt   <= (in_frame && !rx_valid) ? tmo_cnt + TW'(1) : '0;

         if (tmo_hit) begin
            frame_err <= 1'b1;
            err_q     <= ERR_TMO;
            state     <= S_HUNT;
         end else begin
            unique case (state)
               S_HUNT: begin
                  if (rx_valid && rx_byte == SYNC_BYTE) state <= S_ADDR;
               end
               S_ADDR: begin
                  if (rx_valid) begin
                     addr  <= rx_byte;
                     chk   <= rx_byte;
                     state <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (rx_valid) begin
                     if (len_bad(rx_byte, MAX_LEN)) begin
                        frame_err <= 1'b1;
                        err_q     <= ERR_LEN;
                        state     <= S_HUNT;
                     end else begin
                        len   <= rx_byte;
                        chk   <= chk ^ rx_byte;
                        idx   <= '0;
                        state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (rx_valid) begin
                     chk <= chk ^ rx_byte;
                     if (idx == len - 8'd1) begin
                        idx   <= '0;
                        state <= S_CHK;
                     end else begin
                        idx <= idx + 8'd1;
                     end
                  end
               end
               S_CHK: begin
                  if (rx_valid) begin
                     if (rx_byte == chk) begin
                        // First write issues here so it appears the cycle after CHK.
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= buf_rdata;
                        idx     <= 8'd1;
                        state   <= S_DRAIN;
                     end else begin
                        frame_err <= 1'b1;
                        err_q     <= ERR_CHK;
                        state     <= S_HUNT;
                     end
                  end
               end
               S_DRAIN: begin
                  overrun <= rx_valid;
                  if (idx == len) begin
                     frame_ok <= 1'b1;
                     idx      <= '0;
                     state    <= S_HUNT;
                  end else begin
                     wr_en   <= 1'b1;
                     wr_addr <= addr + idx;
                     wr_data <= buf_rdata;
                     idx     <= idx + 8'd1;
                  end
               end
               default: state <= S_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: directed frames push expected writes
// and frame outcomes; a negedge monitor pops and compares.
module tb_uart_cmd_sequencer;

   localparam int MAX_LEN = 16;
   localparam int TIMEOUT = 4096;

   typedef logic [7:0] bytes_t[$];
   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      bit         first;
   } wr_t;
   typedef struct {
      bit         is_err;
      logic [1:0] code;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       overrun;

   wr_t wr_q[$];
   ev_t ev_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  ovr_seen = 0;
   int  ovr_exp = 0;
   bit  prev_wr = 1'b0;

   uart_cmd_sequencer #(
      .MAX_LEN (MAX_LEN),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input bit first);
      wr_t w;
      w.a = a; w.d = d; w.first = first;
      wr_q.push_back(w);
   endtask

   task automatic push_ev(input bit is_err, input logic [1:0] code);
      ev_t e;
      e.is_err = is_err; e.code = code;
      ev_q.push_back(e);
   endtask

   task automatic send(input bytes_t b);
      foreach (b[i]) begin
         @(negedge clk);
         rx_byte  = b[i];
         rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (!busy && wr_q.size() == 0 && ev_q.size() == 0) done = 1'b1;
      end
      check({name, "_idle_reached"}, done, 1);
      @(negedge clk);
      check({name, "_busy_low"}, busy, 0);
   endtask

   // Monitor: every output event must match the head of its expectation queue.
   initial begin
      wr_t w;
      ev_t e;
      forever begin
         @(negedge clk);
         if (wr_en) begin
            check("wr_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
               w = wr_q.pop_front();
               check("wr_addr", wr_addr, w.a);
               check("wr_data", wr_data, w.d);
               if (!w.first) check("wr_consecutive", prev_wr, 1);
            end
         end
         prev_wr = wr_en;
         if (frame_ok || frame_err) begin
            check("ok_err_exclusive", frame_ok & frame_err, 0);
            check("event_expected", ev_q.size() != 0, 1);
            if (ev_q.size() != 0) begin
               e = ev_q.pop_front();
               check("frame_err_vs_ok", frame_err, e.is_err);
               if (e.is_err) check("err_code", err_code, e.code);
            end
         end
         if (overrun) ovr_seen++;
      end
   end

   initial begin
      bytes_t     b;
      logic [7:0] c;

      repeat (3) @(negedge clk);
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_ok", frame_ok, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: basic two-byte frame
      push_wr(8'h10, 8'h11, 1); push_wr(8'h11, 8'h22, 0); push_ev(0, 2'b00);
      send('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      check("t1_first_wr_latency", wr_en, 1);
      wait_idle("t1");

      // 2: address wraps FF -> 00
      push_wr(8'hFF, 8'hAA, 1); push_wr(8'h00, 8'hBB, 0); push_ev(0, 2'b00);
      send('{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC});
      check("t2_first_wr_latency", wr_en, 1);
      wait_idle("t2");

      // 3: bad checksum, then a good frame; err_code holds across the good frame
      push_ev(1, 2'b01);
      send('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20});
      wait_idle("t3_bad");
      push_wr(8'h10, 8'h11, 1); push_wr(8'h11, 8'h22, 0); push_ev(0, 2'b00);
      send('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      wait_idle("t3_good");
      check("t3_err_code_held", err_code, 2'b01);

      // 4: LEN = 0 and LEN = MAX_LEN+1
      push_ev(1, 2'b10);
      send('{8'hA5, 8'h10, 8'h00});
      wait_idle("t4_len0");
      push_ev(1, 2'b10);
      send('{8'hA5, 8'h10, 8'h11});
      wait_idle("t4_len17");

      // Noise before SYNC is ignored; A5 inside the payload is plain data
      push_wr(8'h20, 8'hA5, 1); push_ev(0, 2'b00);
      send('{8'h33, 8'h5A, 8'hA5, 8'h20, 8'h01, 8'hA5, 8'h84});
      wait_idle("t4_a5_data");

      // 5: inter-byte timeout
      push_ev(1, 2'b11);
      send('{8'hA5, 8'h10, 8'h02, 8'h11});
      repeat (TIMEOUT - 2) @(negedge clk);
      check("t5_busy_before_timeout", busy, 1);
      wait_idle("t5");

      // 6: full-length frame with an A5 injected during DRAIN
      b = '{8'hA5, 8'h40, 8'(MAX_LEN)};
      c = 8'h40 ^ 8'(MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
         b.push_back(8'(i * 17));
         c ^= 8'(i * 17);
         push_wr(8'(8'h40 + i), 8'(i * 17), i == 0);
      end
      b.push_back(c);
      push_ev(0, 2'b00);
      send(b);
      @(negedge clk);
      rx_byte  = 8'hA5;
      rx_valid = 1'b1;
      ovr_exp++;
      @(negedge clk);
      rx_valid = 1'b0;
      wait_idle("t6_drain");

      // 6b: reset three writes into a DRAIN
      b = '{8'hA5, 8'hF0, 8'(MAX_LEN)};
      c = 8'hF0 ^ 8'(MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
         b.push_back(8'(i * 17));
         c ^= 8'(i * 17);
      end
      b.push_back(c);
      for (int i = 0; i < 3; i++) push_wr(8'(8'hF0 + i), 8'(i * 17), i == 0);
      send(b);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_wr_en_low", wr_en, 0);
      check("t6_rst_busy_low", busy, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("t6_rst_no_pulse_ok", frame_ok, 0);

      // Recovery after reset
      push_wr(8'h10, 8'h11, 1); push_wr(8'h11, 8'h22, 0); push_ev(0, 2'b00);
      send('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      wait_idle("t6_recover");

      check("end_wr_q_empty", wr_q.size(), 0);
      check("end_ev_q_empty", ev_q.size(), 0);
      check("overrun_count", ovr_seen, ovr_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
